// File: rtl/sub_bytes_iter_if.sv
// sub_bytes_iter_if: handshake bundle between the cipher datapath and the SubBytes stage.
// Latency: none (wires only).
// Backpressure: i_valid/o_ready on the upstream side, o_valid/i_ready on the downstream side.
// Ports: i_valid, i_data[127:0], i_inverse, i_ready (into the stage); o_ready, o_valid, o_data[127:0] (out of it).
// Modports: slave = the SubBytes stage, master = the environment driving it.
interface sub_bytes_iter_if;
   logic         i_valid;
   logic         o_ready;
   logic [127:0] i_data;
   logic         i_inverse;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_data;

   modport slave  (input  i_valid, i_data, i_inverse, i_ready,
                   output o_ready, o_valid, o_data);
   modport master (output i_valid, i_data, i_inverse, i_ready,
                   input  o_ready, o_valid, o_data);
endinterface

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes, LANES arithmetic S-boxes applied to a 128-bit state per clock.
// Latency: o_valid rises after edge E+16/LANES, where E is the accepting edge; the next accept can follow 16/LANES+2 cycles after E.
// Backpressure: o_ready only in IDLE; the result is held in DONE until i_ready.
// Ports: clk, n_rst (async active-low), bus (sub_bytes_iter_if.slave).
// Option: define SUB_BYTES_INV_EN to build the inverse S-box path selected by i_inverse.
module sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   sub_bytes_iter_if.slave  bus
);
   localparam int NPASS = 16 / LANES;
   localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NPASS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t        state;
   logic [127:0]  st;
   logic [CW-1:0] cnt;
   logic          inv;
   logic [127:0]  st_sub;

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // x^-1 = x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 without a special case.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h01;
      s = x;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         p = gf_mul(p, s);
      end
      return p;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

`ifdef SUB_BYTES_INV_EN
   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   // One inverter per lane, shared between directions: the affine step moves
   // to the other side of the inversion for InvS.
   function automatic logic [7:0] sbox(input logic [7:0] b, input logic sel_inv);
      logic [7:0] y;
      y = gf_inv(sel_inv ? inv_affine(b) : b);
      return sel_inv ? y : affine(y);
   endfunction
`else
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return affine(gf_inv(b));
   endfunction

   logic unused_inverse;
   assign inv            = 1'b0;
   assign unused_inverse = bus.i_inverse ^ inv;
`endif

   // Byte k lives at st[127-8k -: 8]; this pass covers bytes cnt*LANES .. cnt*LANES+LANES-1.
   always_comb begin
      st_sub = st;
      for (int l = 0; l < LANES; l++) begin
         int idx;
         idx = int'(cnt) * LANES + l;
`ifdef SUB_BYTES_INV_EN
         st_sub[8*(15-idx) +: 8] = sbox(st[8*(15-idx) +: 8], inv);
`else
         st_sub[8*(15-idx) +: 8] = sbox(st[8*(15-idx) +: 8]);
`endif
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         st    <= '0;
         cnt   <= '0;
`ifdef SUB_BYTES_INV_EN
         inv   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  st    <= bus.i_data;
                  cnt   <= '0;
`ifdef SUB_BYTES_INV_EN
                  inv   <= bus.i_inverse;
`endif
                  state <= BUSY;
               end
            end
            BUSY: begin
               st <= st_sub;
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (bus.i_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_ready = (state == IDLE);
   assign bus.o_valid = (state == DONE);
   assign bus.o_data  = st;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter: runs LANES = 1, 2, 4, 16 instances side by side on shared stimulus
// and compares them against a table-driven S-box model built by brute-force GF(2^8) search.
module tb_sub_bytes_iter;
   localparam int LN [4] = '{1, 2, 4, 16};
   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   logic clk;
   logic n_rst;
   logic         tv_valid;
   logic [127:0] tv_data;
   logic         tv_inv;
   logic         ti_ready;

   logic [3:0]   ov;
   logic [3:0]   ordy;
   logic [127:0] od [4];

   sub_bytes_iter_if bi [4] ();

   for (genvar g = 0; g < 4; g++) begin : g_dut
      assign bi[g].i_valid   = tv_valid;
      assign bi[g].i_data    = tv_data;
      assign bi[g].i_inverse = tv_inv;
      assign bi[g].i_ready   = ti_ready;
      assign ov[g]   = bi[g].o_valid;
      assign ordy[g] = bi[g].o_ready;
      assign od[g]   = bi[g].o_data;
      sub_bytes_iter #(.LANES(LN[g])) dut (.clk(clk), .n_rst(n_rst), .bus(bi[g]));
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   logic [127:0] got [4];
   int           lat [4];
   int           vcnt [4];
   logic         rdy_after [4];

   // Schoolbook polynomial product, then reduction by 0x11B.
   function automatic int m_mul(input int a, input int b);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++) if ((b >> i) & 1) p = p ^ (a << i);
      for (int k = 14; k >= 8; k--) if ((p >> k) & 1) p = p ^ (32'h11b << (k - 8));
      return p;
   endfunction

   function automatic int rotl8(input int v, input int n);
      return ((v << n) | (v >> (8 - n))) & 255;
   endfunction

   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         int iv;
         int s;
         iv = 0;
         for (int y = 1; y < 256; y++) if (m_mul(x, y) == 1) iv = y;
         s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
         sb[x]  = 8'(s);
         isb[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      logic         eff;
`ifdef SUB_BYTES_INV_EN
      eff = inv;
`else
      eff = 1'b0;
`endif
      for (int k = 0; k < 16; k++) begin
         logic [7:0] b;
         b = d[127-8*k -: 8];
         r[127-8*k -: 8] = eff ? isb[b] : sb[b];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for every instance to be idle, then presents one state for one edge.
   task automatic pulse(input logic [127:0] d, input logic inv, output bit ok);
      int n;
      n = 0;
      while (ordy != 4'hf && n < 80) begin
         tick();
         n++;
      end
      ok = (ordy == 4'hf);
      tv_data  = d;
      tv_inv   = inv;
      tv_valid = 1'b1;
      tick();
      tv_valid = 1'b0;
   endtask

   // With i_ready high, records per instance: first valid cycle after E, data, valid length, o_ready after.
   task automatic collect();
      bit seen [4];
      for (int g = 0; g < 4; g++) begin
         lat[g] = -1; vcnt[g] = 0; rdy_after[g] = 1'b0; seen[g] = 1'b0; got[g] = '0;
      end
      for (int n = 1; n <= 40; n++) begin
         tick();
         for (int g = 0; g < 4; g++) begin
            if (ov[g]) begin
               if (lat[g] < 0) begin
                  lat[g] = n;
                  got[g] = od[g];
               end
               vcnt[g]++;
            end else if (lat[g] >= 0 && !seen[g]) begin
               rdy_after[g] = ordy[g];
               seen[g] = 1'b1;
            end
         end
         if (seen[0] && seen[1] && seen[2] && seen[3]) break;
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      tick(); tick();
      for (int g = 0; g < 4; g++) begin
         checks++; if (ordy[g] !== 1'b1) begin errors++; $display("FAIL reset_o_ready[%0d]: got %b want 1", g, ordy[g]); end
         checks++; if (ov[g] !== 1'b0) begin errors++; $display("FAIL reset_o_valid[%0d]: got %b want 0", g, ov[g]); end
         checks++; if (od[g] !== 128'h0) begin errors++; $display("FAIL reset_o_data[%0d]: got %h want 0", g, od[g]); end
      end
      n_rst = 1'b1;
      tick();
   endtask

   task automatic test_zero();
      bit ok;
      pulse(128'h0, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL zero_idle_wait: timed out"); end
      checks++; if (ordy[2] !== 1'b0) begin errors++; $display("FAIL zero_o_ready_after_E: got %b want 0", ordy[2]); end
      collect();
      checks++; if (lat[2] != 4) begin errors++; $display("FAIL zero_latency: got %0d want 4", lat[2]); end
      checks++; if (got[2] !== {16{8'h63}}) begin errors++; $display("FAIL zero_data: got %h want %h", got[2], {16{8'h63}}); end
      checks++; if (vcnt[2] != 1) begin errors++; $display("FAIL zero_valid_len: got %0d want 1", vcnt[2]); end
      checks++; if (rdy_after[2] !== 1'b1) begin errors++; $display("FAIL zero_ready_return: got %b want 1", rdy_after[2]); end
   endtask

   task automatic test_fips();
      bit ok;
      pulse(FIPS_IN, 1'b0, ok);
      collect();
      checks++; if (!ok) begin errors++; $display("FAIL fips_idle_wait: timed out"); end
      checks++; if (got[2] !== FIPS_OUT) begin errors++; $display("FAIL fips_data: got %h want %h", got[2], FIPS_OUT); end
      checks++; if (got[2] !== model(FIPS_IN, 1'b0)) begin errors++; $display("FAIL fips_model: got %h want %h", got[2], model(FIPS_IN, 1'b0)); end
   endtask

   task automatic test_backpressure();
      bit ok;
      int n;
      ti_ready = 1'b0;
      pulse(FIPS_IN, 1'b0, ok);
      n = 0;
      while (!ov[2] && n < 40) begin tick(); n++; end
      checks++; if (!ok || !ov[2]) begin errors++; $display("FAIL bp_wait_valid: ok=%b o_valid=%b want both 1", ok, ov[2]); end
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin tv_data = ~FIPS_IN; tv_valid = 1'b1; end
         tick();
         tv_valid = 1'b0;
         checks++; if (ov[2] !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", k, ov[2]); end
         checks++; if (od[2] !== FIPS_OUT) begin errors++; $display("FAIL bp_data_hold[%0d]: got %h want %h", k, od[2], FIPS_OUT); end
      end
      ti_ready = 1'b1;
      tick();
      checks++; if (ordy[2] !== 1'b1 || ov[2] !== 1'b0) begin errors++; $display("FAIL bp_release: o_ready=%b o_valid=%b want 1/0", ordy[2], ov[2]); end
      checks++; if (od[2] !== FIPS_OUT) begin errors++; $display("FAIL bp_no_capture: got %h want %h", od[2], FIPS_OUT); end
   endtask

   task automatic test_reset_busy();
      bit ok;
      logic [127:0] pat;
      pulse({$urandom, $urandom, $urandom, $urandom}, 1'b0, ok);
      tick(); tick();
      n_rst = 1'b0;
      #1;
      checks++; if (ordy[2] !== 1'b1 || ov[2] !== 1'b0) begin errors++; $display("FAIL rb_flags: o_ready=%b o_valid=%b want 1/0", ordy[2], ov[2]); end
      checks++; if (od[2] !== 128'h0) begin errors++; $display("FAIL rb_data: got %h want 0", od[2]); end
      #2;
      n_rst = 1'b1;
      pat = {4{32'h0053ff01}};
      pulse(pat, 1'b0, ok);
      collect();
      checks++; if (!ok) begin errors++; $display("FAIL rb_idle_wait: timed out"); end
      checks++; if (got[2] !== model(pat, 1'b0)) begin errors++; $display("FAIL rb_result: got %h want %h", got[2], model(pat, 1'b0)); end
      checks++; if (lat[2] != 4) begin errors++; $display("FAIL rb_latency: got %0d want 4", lat[2]); end
   endtask

   task automatic test_inverse();
      bit ok;
      pulse(FIPS_OUT, 1'b1, ok);
      collect();
      checks++; if (!ok) begin errors++; $display("FAIL inv_idle_wait: timed out"); end
      checks++; if (got[2] !== model(FIPS_OUT, 1'b1)) begin errors++; $display("FAIL inv_model: got %h want %h", got[2], model(FIPS_OUT, 1'b1)); end
`ifdef SUB_BYTES_INV_EN
      checks++; if (got[2] !== FIPS_IN) begin errors++; $display("FAIL inv_data: got %h want %h", got[2], FIPS_IN); end
`else
      checks++; if (got[2][127:120] !== 8'h48) begin errors++; $display("FAIL inv_ignored_byte0: got %h want 48", got[2][127:120]); end
`endif
   endtask

   task automatic test_lanes_sweep();
      bit ok;
      pulse(FIPS_IN, 1'b0, ok);
      collect();
      checks++; if (!ok) begin errors++; $display("FAIL sweep_idle_wait: timed out"); end
      for (int g = 0; g < 4; g++) begin
         checks++; if (lat[g] != 16 / LN[g]) begin errors++; $display("FAIL sweep_latency[L=%0d]: got %0d want %0d", LN[g], lat[g], 16 / LN[g]); end
         checks++; if (got[g] !== FIPS_OUT) begin errors++; $display("FAIL sweep_data[L=%0d]: got %h want %h", LN[g], got[g], FIPS_OUT); end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         bit ok;
         logic [127:0] d;
         logic inv;
         d   = {$urandom, $urandom, $urandom, $urandom};
         inv = 1'($urandom_range(0, 1));
         pulse(d, inv, ok);
         collect();
         checks++; if (!ok) begin errors++; $display("FAIL rand_idle_wait[%0d]: timed out", t); end
         for (int g = 0; g < 4; g++) begin
            checks++; if (got[g] !== model(d, inv)) begin errors++; $display("FAIL rand_data[%0d,L=%0d]: got %h want %h", t, LN[g], got[g], model(d, inv)); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int stamps [$];
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      tv_data  = d;
      tv_inv   = 1'b0;
      tv_valid = 1'b1;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (ov[2]) begin
            stamps.push_back(n);
            checks++; if (od[2] !== model(d, 1'b0)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", n, od[2], model(d, 1'b0)); end
         end
      end
      tv_valid = 1'b0;
      checks++; if (stamps.size() < 5) begin errors++; $display("FAIL b2b_count: got %0d want >=5", stamps.size()); end
      for (int i = 1; i < stamps.size(); i++) begin
         checks++; if (stamps[i] - stamps[i-1] != 6) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 6", i, stamps[i] - stamps[i-1]); end
      end
      repeat (40) tick();
   endtask

   initial begin
      n_rst    = 1'b0;
      tv_valid = 1'b0;
      tv_data  = '0;
      tv_inv   = 1'b0;
      ti_ready = 1'b1;
      build_tables();
      test_reset();
      test_zero();
      test_fips();
      test_backpressure();
      test_reset_busy();
      test_inverse();
      test_lanes_sweep();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
